// File: rtl/signal_measure_multi.sv
// Multi-period frequency/duty measurement: accumulates 2^k periods of a synchronised input,
// then divides with one shared restoring divider. Optional glitch filter: SMM_GLITCH_FILTER_EN.
module signal_measure_multi #(
  parameter logic [31:0] CLK_FREQ    = 32'd50_000_000,
  parameter int          CNT_W       = 24,
  parameter int          AVG_MAX     = 4,
  parameter int          TIMEOUT_CYC = 2_000_000,
  parameter int          FILT_LEN    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [3:0]       avg_log2,
  input  logic             sig_in,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] period_sum,
  output logic [CNT_W-1:0] high_sum,
  output logic [31:0]      freq,
  output logic [9:0]       duty
);
  localparam int FN_W  = 40;
  localparam int DN_W  = CNT_W + 10;
  localparam int NUM_W = (FN_W > DN_W) ? FN_W : DN_W;
  localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int CYC_W = $clog2(NUM_W + 1);
  localparam logic [3:0]      K_MAX   = 4'(AVG_MAX);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_MEAS, S_DIV_F, S_DIV_D, S_DONE} state_t;

  state_t             state_q, state_d;
  logic               sync1_q, s_q, sf, sf_prev_q, rise;
  logic [3:0]         k_q, k_d;
  logic [8:0]         edges_q, edges_d;
  logic [CNT_W-1:0]   period_acc_q, period_acc_d, high_acc_q, high_acc_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic [NUM_W-1:0]   num_q, num_d, num_step, f_num_al, d_num_al;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic [31:0]        freq_tmp_q, freq_tmp_d, freq_q, freq_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   period_sum_q, period_sum_d, high_sum_q, high_sum_d;
  logic [9:0]         duty_q, duty_d;
  logic [CNT_W:0]     trial, diff;
  logic               q_bit, wd_hit, ovf;
  logic [FN_W-1:0]    f_num;
  logic [DN_W-1:0]    d_num;

`ifdef SMM_GLITCH_FILTER_EN
  localparam int FC_W = $clog2(FILT_LEN + 1);
  logic            sf_q, sf_d;
  logic [FC_W-1:0] filt_cnt_q, filt_cnt_d;

  // sf follows s only after s has disagreed with it for FILT_LEN consecutive clocks
  always_comb begin
    sf_d       = sf_q;
    filt_cnt_d = '0;
    if (s_q != sf_q) begin
      if (filt_cnt_q == FC_W'(FILT_LEN - 1)) sf_d = s_q;
      else                                   filt_cnt_d = filt_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sf_q       <= 1'b0;
      filt_cnt_q <= '0;
    end else begin
      sf_q       <= sf_d;
      filt_cnt_q <= filt_cnt_d;
    end
  end

  assign sf = sf_q;
`else
  assign sf = s_q;
`endif

  assign rise = sf & ~sf_prev_q;

  // Divider step; a borrow out of diff means the trial remainder is below the divisor.
  assign trial    = {rem_q, num_q[NUM_W-1]};
  assign diff     = trial - {1'b0, period_acc_q};
  assign q_bit    = ~diff[CNT_W];
  assign num_step = {num_q[NUM_W-2:0], q_bit};

  // Numerators are left-aligned so quotient bits land in the low end after FN_W/DN_W steps.
  assign f_num    = FN_W'(CLK_FREQ) << k_q;
  assign f_num_al = NUM_W'(f_num) << (NUM_W - FN_W);
  assign d_num    = DN_W'(high_acc_q) * DN_W'(1000);
  assign d_num_al = NUM_W'(d_num) << (NUM_W - DN_W);

  assign wd_hit = (wd_q == WD_LAST) && !rise;
  assign ovf    = &period_acc_q;

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    edges_d      = edges_q;
    period_acc_d = period_acc_q;
    high_acc_d   = high_acc_q;
    wd_d         = wd_q;
    num_d        = num_q;
    rem_d        = rem_q;
    cyc_d        = cyc_q;
    freq_tmp_d   = freq_tmp_q;
    timeout_d    = timeout_q;
    period_sum_d = period_sum_q;
    high_sum_d   = high_sum_q;
    freq_d       = freq_q;
    duty_d       = duty_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          k_d     = (avg_log2 > K_MAX) ? K_MAX : avg_log2;
          wd_d    = '0;
          state_d = S_ARM;
        end
        S_ARM, S_MEAS: begin
          wd_d = rise ? '0 : wd_q + 1'b1;
          if (wd_hit || (state_q == S_MEAS && ovf)) begin
            state_d      = S_DONE;
            timeout_d    = 1'b1;
            period_sum_d = '0;
            high_sum_d   = '0;
            freq_d       = '0;
            duty_d       = '0;
          end else if (state_q == S_ARM) begin
            if (rise) begin
              period_acc_d = CNT_W'(1);
              high_acc_d   = CNT_W'(1);
              edges_d      = '0;
              state_d      = S_MEAS;
            end
          end else if (rise) begin
            if ((edges_q + 9'd1) == (9'd1 << k_q)) begin
              num_d   = f_num_al;
              rem_d   = '0;
              cyc_d   = '0;
              state_d = S_DIV_F;
            end else begin
              edges_d      = edges_q + 9'd1;
              period_acc_d = period_acc_q + 1'b1;
              high_acc_d   = high_acc_q + 1'b1;
            end
          end else begin
            period_acc_d = period_acc_q + 1'b1;
            high_acc_d   = high_acc_q + CNT_W'(sf);
          end
        end
        S_DIV_F: begin
          num_d = num_step;
          rem_d = q_bit ? diff[CNT_W-1:0] : trial[CNT_W-1:0];
          cyc_d = cyc_q + 1'b1;
          if (cyc_q == CYC_W'(FN_W - 1)) begin
            freq_tmp_d = num_step[31:0];
            num_d      = d_num_al;
            rem_d      = '0;
            cyc_d      = '0;
            state_d    = S_DIV_D;
          end
        end
        S_DIV_D: begin
          num_d = num_step;
          rem_d = q_bit ? diff[CNT_W-1:0] : trial[CNT_W-1:0];
          cyc_d = cyc_q + 1'b1;
          if (cyc_q == CYC_W'(DN_W - 1)) begin
            timeout_d    = 1'b0;
            period_sum_d = period_acc_q;
            high_sum_d   = high_acc_q;
            freq_d       = freq_tmp_q;
            duty_d       = num_step[9:0];
            state_d      = S_DONE;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      sync1_q      <= 1'b0;
      s_q          <= 1'b0;
      sf_prev_q    <= 1'b0;
      k_q          <= '0;
      edges_q      <= '0;
      period_acc_q <= '0;
      high_acc_q   <= '0;
      wd_q         <= '0;
      num_q        <= '0;
      rem_q        <= '0;
      cyc_q        <= '0;
      freq_tmp_q   <= '0;
      timeout_q    <= 1'b0;
      period_sum_q <= '0;
      high_sum_q   <= '0;
      freq_q       <= '0;
      duty_q       <= '0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sig_in;
      s_q          <= sync1_q;
      sf_prev_q    <= sf;
      k_q          <= k_d;
      edges_q      <= edges_d;
      period_acc_q <= period_acc_d;
      high_acc_q   <= high_acc_d;
      wd_q         <= wd_d;
      num_q        <= num_d;
      rem_q        <= rem_d;
      cyc_q        <= cyc_d;
      freq_tmp_q   <= freq_tmp_d;
      timeout_q    <= timeout_d;
      period_sum_q <= period_sum_d;
      high_sum_q   <= high_sum_d;
      freq_q       <= freq_d;
      duty_q       <= duty_d;
    end
  end

  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE);
  end

  assign timeout    = timeout_q;
  assign period_sum = period_sum_q;
  assign high_sum   = high_sum_q;
  assign freq       = freq_q;
  assign duty       = duty_q;
endmodule

// File: tb/tb_signal_measure_multi.sv
// Randomised bench for signal_measure_multi against an arithmetic model of the measurement.
module tb_signal_measure_multi;
  localparam int     CNT_W       = 12;
  localparam int     AVG_MAX     = 4;
  localparam int     TIMEOUT_CYC = 1000;
  localparam longint CLK_HZ      = 50_000_000;

  logic             clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, sig_in = 1'b0;
  logic [3:0]       avg_log2 = '0;
  logic             busy, done, timeout;
  logic [CNT_W-1:0] period_sum, high_sum;
  logic [31:0]      freq;
  logic [9:0]       duty;

  int     n_chk = 0, n_pass = 0;
  int     per_v = 100, hi_v = 30, phase = 0, last_lat = 0;
  bit     stuck = 1'b0, restart = 1'b0;
  longint e_ps = 0, e_hs = 0, e_freq = 0, e_duty = 0, e_to = 0;

  always #5 clk = ~clk;

  signal_measure_multi #(
    .CLK_FREQ(32'd50_000_000), .CNT_W(CNT_W), .AVG_MAX(AVG_MAX),
    .TIMEOUT_CYC(TIMEOUT_CYC), .FILT_LEN(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .avg_log2(avg_log2),
    .sig_in(sig_in), .busy(busy), .done(done), .timeout(timeout),
    .period_sum(period_sum), .high_sum(high_sum), .freq(freq), .duty(duty)
  );

  // Periodic waveform: high for hi_v clocks out of every per_v
  initial begin : wave_gen
    forever begin
      @(negedge clk);
      if (restart) begin
        phase   = hi_v;
        restart = 1'b0;
      end
      sig_in = stuck ? 1'b1 : (phase < hi_v);
      phase  = (phase + 1 >= per_v) ? 0 : phase + 1;
    end
  end

  task automatic chk_val(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Expected results of averaging 2^k whole periods of the steady waveform
  function automatic void model(input int p, input int h, input int avg);
    int     k = (avg > AVG_MAX) ? AVG_MAX : avg;
    longint n = longint'(1) << k;
    longint ps = n * p;
    if (ps >= (longint'(1) << CNT_W) - 1) begin
      e_to = 1; e_ps = 0; e_hs = 0; e_freq = 0; e_duty = 0;
    end else begin
      e_to   = 0;
      e_ps   = ps;
      e_hs   = n * h;
      e_freq = (CLK_HZ << k) / ps;
      e_duty = (e_hs * 1000) / ps;
    end
  endfunction

  task automatic chk_outputs(input string tag);
    chk_val({tag, "_timeout"}, timeout, e_to);
    chk_val({tag, "_period_sum"}, period_sum, e_ps);
    chk_val({tag, "_high_sum"}, high_sum, e_hs);
    chk_val({tag, "_freq"}, freq, e_freq);
    chk_val({tag, "_duty"}, duty, e_duty);
  endtask

  task automatic setup_wave(input int p, input int h);
    @(posedge clk); #1;
    per_v = p; hi_v = h; stuck = 1'b0; restart = 1'b1;
    repeat (2 * p + 8) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int avg);
    avg_log2 = 4'(avg);
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    last_lat = n;
    if (!done) chk_val({tag, "_done_wait"}, 0, 1);
  endtask

  // Done cycle: outputs valid, busy still high, a start here must be ignored
  task automatic finish_done(input string tag);
    chk_outputs(tag);
    chk_val({tag, "_busy_at_done"}, busy, 1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk_val({tag, "_start_in_done"}, busy, 0);
  endtask

  task automatic run_meas(input int p, input int h, input int avg, input string tag);
    setup_wave(p, h);
    model(p, h, avg);
    pulse_start(avg);
    chk_val({tag, "_busy"}, busy, 1);
    wait_done(tag, 20000);
    if (done) finish_done(tag);
  endtask

  initial begin : main
    int seen;
    repeat (3) @(posedge clk);
    #1;
    chk_val("rst_busy", busy, 0);
    chk_val("rst_done", done, 0);
    chk_outputs("rst");
    rst_n = 1'b1;

    run_meas(100, 30, 0, "k0");
    run_meas(100, 30, 2, "k2");
    run_meas(100, 30, 15, "k_clamp");

    // Input stuck high: watchdog ends the measurement with zeroed results
    @(posedge clk); #1;
    stuck = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    e_to = 1; e_ps = 0; e_hs = 0; e_freq = 0; e_duty = 0;
    pulse_start(0);
    wait_done("wd", 3 * TIMEOUT_CYC);
    if (done) begin
      chk_val("wd_latency", last_lat, TIMEOUT_CYC);
      finish_done("wd");
    end
    run_meas(100, 30, 0, "after_wd");

    // Abort mid-measurement: busy drops, no done, previous results kept
    setup_wave(100, 30);
    pulse_start(2);
    repeat (150) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk_val("abort_busy", busy, 0);
    seen = 0;
    repeat (600) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    chk_val("abort_no_done", seen, 0);
    chk_outputs("abort_hold");
    run_meas(100, 30, 2, "after_abort");

    // start and abort together in IDLE: abort wins
    abort = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0;
    chk_val("idle_abort_start", busy, 0);

    run_meas(300, 100, 4, "ovf");

    for (int i = 0; i < 6; i++) begin
      int p = $urandom_range(260, 20);
      int h = $urandom_range(p - 1, 1);
      int a = $urandom_range(15, 0);
      run_meas(p, h, a, $sformatf("rnd%0d", i));
    end

    // Reset asserted while the duty division is running
    run_meas(100, 30, 0, "pre_rst");
    setup_wave(100, 30);
    pulse_start(0);
    repeat (last_lat - 10) @(posedge clk);
    #1;
    chk_val("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    e_to = 0; e_ps = 0; e_hs = 0; e_freq = 0; e_duty = 0;
    chk_val("mid_rst_busy", busy, 0);
    chk_val("mid_rst_done", done, 0);
    chk_outputs("mid_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
